// File: rtl/isr_return_ctrl.sv
// Return-from-interrupt controller: EPC nesting stack, priority tracking, RTI stall/flush/redirect.
// Latency: push visible next cycle; RTI redirect 4 cycles after rti_dec plus hazard cycles; rti_hazard stalls IF/ID.
module isr_return_ctrl #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rti_dec,
    input  logic            data_hazard,
    input  logic            control_hazard,
    input  logic            pop_hazard,
    input  logic            isr_enter_gt,
    input  logic            isr_enter_kb,
    input  logic            isr_enter_so,
    input  logic [PC_W-1:0] epc_in,
    output logic            rti_hazard,
    output logic            flush_ifid,
    output logic            ld_pc_epc,
    output logic [PC_W-1:0] return_pc,
    output logic            allow_gt,
    output logic            allow_kb,
    output logic            allow_so,
    output logic            in_isr,
    output logic [1:0]      cur_level,
    output logic            rti_illegal,
    output logic            nest_ovf,
    output logic            proto_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam int ENT_W = PC_W + 2;

    typedef enum logic [1:0] {IDLE, WAIT_HAZ, FLUSH, REDIRECT} state_t;

    state_t                        state;
    logic [DEPTH-1:0][ENT_W-1:0]   stack;
    logic [CNT_W-1:0]              depth;
    logic [CNT_W-1:0]              depth_m1;
    logic [1:0]                    flush_cnt;
    logic [ENT_W-1:0]              top_ent;
    logic                          hazard;
    logic                          idle;
    logic                          enter_any;
    logic                          enter_multi;
    logic                          stack_full;
    logic                          push_ok;
    logic [1:0]                    enter_lvl;

    assign hazard      = data_hazard | control_hazard | pop_hazard;
    assign idle        = (state == IDLE);
    assign enter_any   = isr_enter_gt | isr_enter_kb | isr_enter_so;
    assign enter_multi = (isr_enter_gt & isr_enter_kb) | (isr_enter_gt & isr_enter_so) |
                         (isr_enter_kb & isr_enter_so);
    assign stack_full  = (depth == CNT_W'(DEPTH));
    assign push_ok     = enter_any & ~enter_multi & idle & ~stack_full;
    assign depth_m1    = depth - CNT_W'(1);

    always_comb begin
        enter_lvl = 2'd3;
        if (isr_enter_gt)
            enter_lvl = 2'd1;
        else if (isr_enter_kb)
            enter_lvl = 2'd2;
    end

    assign top_ent   = (depth == '0) ? '0 : stack[depth_m1[IDX_W-1:0]];
    assign cur_level = top_ent[ENT_W-1 -: 2];
    assign return_pc = top_ent[PC_W-1:0];
    assign in_isr    = (depth != '0);

    // Enables drop while an RTI is in flight so no new entry races the pop.
    assign allow_gt = idle & (cur_level < 2'd1);
    assign allow_kb = idle & (cur_level < 2'd2);
    assign allow_so = idle & (cur_level < 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            stack       <= '0;
            depth       <= '0;
            flush_cnt   <= 2'd0;
            rti_hazard  <= 1'b0;
            flush_ifid  <= 1'b0;
            ld_pc_epc   <= 1'b0;
            rti_illegal <= 1'b0;
            nest_ovf    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            rti_illegal <= 1'b0;
            ld_pc_epc   <= 1'b0;

            if (enter_any) begin
                if (!idle || enter_multi)
                    proto_err <= 1'b1;
                else if (stack_full)
                    nest_ovf <= 1'b1;
            end
            if (push_ok)
                stack[depth[IDX_W-1:0]] <= {enter_lvl, epc_in};

            case (state)
                IDLE: begin
                    if (push_ok)
                        depth <= depth + CNT_W'(1);
                    // A same-cycle push makes the stack non-empty, so the RTI returns from it.
                    if (rti_dec) begin
                        if (depth == '0 && !push_ok) begin
                            rti_illegal <= 1'b1;
                        end else begin
                            state      <= WAIT_HAZ;
                            rti_hazard <= 1'b1;
                        end
                    end
                end
                WAIT_HAZ: begin
                    if (!hazard) begin
                        flush_cnt  <= 2'd0;
                        flush_ifid <= 1'b1;
                        state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 2'd1;
                    if (flush_cnt == 2'd1) begin
                        flush_ifid <= 1'b0;
                        ld_pc_epc  <= 1'b1;
                        state      <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    depth      <= depth_m1;
                    rti_hazard <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isr_return_ctrl.sv
// Directed bench for isr_return_ctrl: stack/sequence model checked every cycle plus literal expectations.
module tb_isr_return_ctrl;

    localparam int DEPTH = 4;
    localparam int PC_W  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rti_dec = 1'b0;
    logic            data_hazard = 1'b0, control_hazard = 1'b0, pop_hazard = 1'b0;
    logic            isr_enter_gt = 1'b0, isr_enter_kb = 1'b0, isr_enter_so = 1'b0;
    logic [PC_W-1:0] epc_in = '0;
    logic            rti_hazard, flush_ifid, ld_pc_epc;
    logic [PC_W-1:0] return_pc;
    logic            allow_gt, allow_kb, allow_so, in_isr;
    logic [1:0]      cur_level;
    logic            rti_illegal, nest_ovf, proto_err;

    isr_return_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .rti_dec(rti_dec),
        .data_hazard(data_hazard), .control_hazard(control_hazard), .pop_hazard(pop_hazard),
        .isr_enter_gt(isr_enter_gt), .isr_enter_kb(isr_enter_kb), .isr_enter_so(isr_enter_so),
        .epc_in(epc_in), .rti_hazard(rti_hazard), .flush_ifid(flush_ifid), .ld_pc_epc(ld_pc_epc),
        .return_pc(return_pc), .allow_gt(allow_gt), .allow_kb(allow_kb), .allow_so(allow_so),
        .in_isr(in_isr), .cur_level(cur_level), .rti_illegal(rti_illegal),
        .nest_ovf(nest_ovf), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fl_count = 0;
    int hz_count = 0;
    int ld_cyc[$];
    logic [PC_W-1:0] ld_pc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a LIFO of {level, epc} and an RTI in flight described by whether the
    // hazard has cleared and how many cycles have elapsed since it did.
    logic [PC_W+1:0] mstack[$];
    bit  m_busy, m_cleared, m_ovf, m_perr, m_ill;
    int  m_post;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mstack.delete();
            m_busy = 0; m_cleared = 0; m_post = 0;
            m_ovf = 0; m_perr = 0; m_ill = 0;
        end else begin
            int n;
            logic [1:0] lvl;
            bit was_idle;
            was_idle = !m_busy;
            n = int'(isr_enter_gt) + int'(isr_enter_kb) + int'(isr_enter_so);
            lvl = isr_enter_gt ? 2'd1 : (isr_enter_kb ? 2'd2 : 2'd3);
            m_ill = 0;
            if (n > 0) begin
                if (!was_idle || n > 1) m_perr = 1;
                else if (mstack.size() == DEPTH) m_ovf = 1;
                else mstack.push_back({lvl, epc_in});
            end
            if (was_idle) begin
                if (rti_dec) begin
                    if (mstack.size() == 0) m_ill = 1;
                    else begin m_busy = 1; m_cleared = 0; end
                end
            end else if (!m_cleared) begin
                if (!(data_hazard || control_hazard || pop_hazard)) begin
                    m_cleared = 1; m_post = 1;
                end
            end else if (m_post == 3) begin
                void'(mstack.pop_back());
                m_busy = 0;
            end else begin
                m_post++;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [1:0]      e_lvl;
        logic [PC_W-1:0] e_pc;
        bit              e_idle;
        e_lvl  = (mstack.size() == 0) ? 2'd0 : mstack[$][PC_W+1:PC_W];
        e_pc   = (mstack.size() == 0) ? '0 : mstack[$][PC_W-1:0];
        e_idle = !m_busy;
        chk("rti_hazard", rti_hazard, m_busy);
        chk("flush_ifid", flush_ifid, m_busy && m_cleared && m_post < 3);
        chk("ld_pc_epc", ld_pc_epc, m_busy && m_cleared && m_post == 3);
        chk("return_pc", return_pc, e_pc);
        chk("cur_level", cur_level, e_lvl);
        chk("in_isr", in_isr, mstack.size() != 0);
        chk("allow_gt", allow_gt, e_idle && e_lvl < 1);
        chk("allow_kb", allow_kb, e_idle && e_lvl < 2);
        chk("allow_so", allow_so, e_idle && e_lvl < 3);
        chk("rti_illegal", rti_illegal, m_ill);
        chk("nest_ovf", nest_ovf, m_ovf);
        chk("proto_err", proto_err, m_perr);
        if (flush_ifid) fl_count++;
        if (rti_hazard) hz_count++;
        if (ld_pc_epc) begin
            ld_cyc.push_back(cyc);
            ld_pc.push_back(return_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int src, input logic [PC_W-1:0] pc);
        isr_enter_gt = (src == 1);
        isr_enter_kb = (src == 2);
        isr_enter_so = (src == 3);
        epc_in = pc;
        tick();
        isr_enter_gt = 0; isr_enter_kb = 0; isr_enter_so = 0;
        epc_in = '0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while (rti_hazard && n < 30) begin
            tick();
            n++;
        end
        chk("rti_timeout", rti_hazard, 1'b0);
    endtask

    task automatic do_rti(output int t);
        t = cyc;
        rti_dec = 1;
        tick();
        rti_dec = 0;
        wait_quiet();
    endtask

    initial begin
        int t, n0;
        tick(); tick();
        chk("rst_allow_gt", allow_gt, 1'b1);
        chk("rst_level", cur_level, 2'd0);
        chk("rst_retpc", return_pc, '0);
        rst = 0;
        tick();

        // Basic return from a keyboard ISR
        push(2, 16'h1234);
        chk("basic_level", cur_level, 2'd2);
        chk("basic_allow_kb", allow_kb, 1'b0);
        fl_count = 0;
        do_rti(t);
        chk("basic_ld_cyc", ld_cyc[$], t + 4);
        chk("basic_ld_pc", ld_pc[$], 16'h1234);
        chk("basic_flush_cycles", fl_count, 2);
        chk("basic_in_isr", in_isr, 1'b0);

        // Nesting and priority
        push(1, 16'h0100);
        push(3, 16'h0200);
        chk("nest_level", cur_level, 2'd3);
        chk("nest_allow_any", {allow_gt, allow_kb, allow_so}, 3'b000);
        do_rti(t);
        chk("nest_pc1", ld_pc[$], 16'h0200);
        chk("nest_level1", cur_level, 2'd1);
        chk("nest_allow1", {allow_gt, allow_kb}, 2'b01);
        do_rti(t);
        chk("nest_pc2", ld_pc[$], 16'h0100);
        chk("nest_level2", cur_level, 2'd0);

        // Hazard stall: pop_hazard high in T+1..T+3
        push(1, 16'h0300);
        hz_count = 0;
        t = cyc;
        rti_dec = 1; pop_hazard = 1;
        tick(); rti_dec = 0;
        tick(); tick(); tick();
        pop_hazard = 0;
        wait_quiet();
        chk("haz_ld_cyc", ld_cyc[$], t + 7);
        chk("haz_ld_pc", ld_pc[$], 16'h0300);
        chk("haz_stall_cycles", hz_count, 7);

        // Illegal RTI on an empty stack
        n0 = ld_cyc.size();
        rti_dec = 1;
        tick(); rti_dec = 0;
        chk("ill_pulse", rti_illegal, 1'b1);
        chk("ill_no_stall", rti_hazard, 1'b0);
        tick();
        chk("ill_pulse_end", rti_illegal, 1'b0);
        tick(); tick(); tick(); tick();
        chk("ill_no_load", ld_cyc.size(), n0);

        // Overflow: fifth push dropped
        for (int i = 0; i < 5; i++) push(2, 16'hA000 + 16'(i));
        chk("ovf_flag", nest_ovf, 1'b1);
        n0 = ld_pc.size();
        for (int i = 0; i < 4; i++) do_rti(t);
        chk("ovf_count", ld_pc.size() - n0, 4);
        chk("ovf_pc0", ld_pc[n0], 16'hA003);
        chk("ovf_pc3", ld_pc[n0 + 3], 16'hA000);
        chk("ovf_empty", in_isr, 1'b0);

        // Entry during FLUSH is a protocol error and is dropped
        push(2, 16'h0555);
        rti_dec = 1;
        tick(); rti_dec = 0;
        tick();
        isr_enter_gt = 1; epc_in = 16'h0777;
        tick();
        isr_enter_gt = 0; epc_in = '0;
        wait_quiet();
        chk("perr_flag", proto_err, 1'b1);
        chk("perr_pc", ld_pc[$], 16'h0555);
        chk("perr_empty", in_isr, 1'b0);

        // Async reset while in FLUSH
        push(3, 16'h0999);
        rti_dec = 1;
        tick(); rti_dec = 0;
        tick();
        chk("rst_seq_in_flush", flush_ifid, 1'b1);
        n0 = ld_cyc.size();
        #2 rst = 1;
        #1;
        chk("arst_flush", flush_ifid, 1'b0);
        chk("arst_stall", rti_hazard, 1'b0);
        chk("arst_allow", {allow_gt, allow_kb, allow_so}, 3'b111);
        chk("arst_in_isr", in_isr, 1'b0);
        chk("arst_sticky", {nest_ovf, proto_err}, 2'b00);
        tick();
        rst = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("arst_no_load", ld_cyc.size(), n0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
